shift_right_seq: RTL and testbench

//  Multi-cycle symbol shifter that sits directly upstream of the 50-bit, 5-bit-symbol

---
 rtl/shift_right_seq.sv | 117 +++++++++++
 tb/tb_shift_right_seq.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/shift_right_seq.sv
// Multi-cycle symbol right-shifter: applies a 0..LANES symbol shift in passes of at
// most MAX_STEP symbols and returns the result through a valid/ready handshake.
module shift_right_seq #(
    parameter int LANES    = 10,
    parameter int SYM_W    = 5,
    parameter int MAX_STEP = 4,
    parameter int SHIFT_W  = $clog2(LANES + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*SYM_W-1:0]   in_data,
    input  logic [SHIFT_W-1:0]       in_shift,
    input  logic [SYM_W-1:0]         in_fill,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*SYM_W-1:0]   out_data,
    output logic                     out_err,
    output logic                     busy
);

    localparam int W = LANES * SYM_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [W-1:0]         data_q;
    logic [SYM_W-1:0]     fill_q;
    logic [SHIFT_W-1:0]   rem_q;
    logic                 err_q;

    logic                 accept;
    logic                 req_err;
    logic [SHIFT_W-1:0]   req_rem;
    logic [SHIFT_W-1:0]   step;

    // One pass of the downstream shifter: lane i takes lane i+step, vacated lanes take fill.
    function automatic logic [W-1:0] shift_pass(input logic [W-1:0]       d,
                                                input logic [SHIFT_W-1:0] s,
                                                input logic [SYM_W-1:0]   fill);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < LANES; i++) begin
            if (i + int'(s) < LANES)
                r[i*SYM_W +: SYM_W] = d[(i + int'(s))*SYM_W +: SYM_W];
            else
                r[i*SYM_W +: SYM_W] = fill;
        end
        return r;
    endfunction

    assign accept  = in_valid && in_ready;
    // An out-of-range request shifts every lane out, leaving an all-fill word.
    assign req_err = in_shift > SHIFT_W'(LANES);
    assign req_rem = req_err ? SHIFT_W'(LANES) : in_shift;
    assign step    = (rem_q > SHIFT_W'(MAX_STEP)) ? SHIFT_W'(MAX_STEP) : rem_q;

    // NOTE: every signal driven here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept)
                    state_d = (req_rem == '0) ? DONE : SHIFT;
            end
            SHIFT: begin
                if (rem_q == step)
                    state_d = DONE;
            end
            DONE: begin
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state and datapath registers use non-blocking assignments so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // NOTE: the data register is reset too, because out_data must read zero after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            fill_q <= '0;
            rem_q  <= '0;
            err_q  <= 1'b0;
        end else if (accept) begin
            data_q <= in_data;
            fill_q <= in_fill;
            rem_q  <= req_rem;
            err_q  <= req_err;
        end else if (state_q == SHIFT) begin
            data_q <= shift_pass(data_q, step, fill_q);
            rem_q  <= rem_q - step;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_data  = data_q;
    assign out_err   = err_q;

endmodule

// File: tb/tb_shift_right_seq.sv
// Scoreboard bench for shift_right_seq: a driver pushes expected results, a monitor
// pops and compares them whenever the output handshake completes.
module tb_shift_right_seq;

    localparam int W = 50;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [3:0]    in_shift;
    logic [4:0]    in_fill;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          out_err;
    logic          busy;

    shift_right_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shift  (in_shift),
        .in_fill   (in_fill),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] data;
        logic         err;
        int           lat;
    } exp_t;

    exp_t         sb[$];
    int           nchecks = 0;
    int           nerrs   = 0;
    int           cyc     = 0;
    int           accept_cyc = 0;
    logic [W-1:0] base_word;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrs++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        nchecks++;
        nerrs++;
        $display("FAIL %s", name);
    endtask

    function automatic logic [W-1:0] mk_word(input int l0, input int l1, input int l2,
                                             input int l3, input int l4, input int l5,
                                             input int l6, input int l7, input int l8,
                                             input int l9);
        logic [W-1:0] w;
        w = {5'(l9), 5'(l8), 5'(l7), 5'(l6), 5'(l5), 5'(l4), 5'(l3), 5'(l2), 5'(l1), 5'(l0)};
        return w;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: latency on the first out_valid cycle, stability under backpressure,
    // payload on handshake, and in_ready returning the cycle after the handshake.
    initial begin
        logic         prev_valid, prev_ready, prev_hs, prev_err, seen;
        logic [W-1:0] prev_data;
        exp_t         e;
        prev_valid = 1'b0; prev_ready = 1'b0; prev_hs = 1'b0; prev_err = 1'b0;
        seen = 1'b0; prev_data = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_valid = 1'b0; prev_hs = 1'b0; seen = 1'b0;
            end else begin
                if (prev_hs) begin
                    check("in_ready_after_hs", 64'(in_ready), 64'd1);
                    check("valid_drop_after_hs", 64'(out_valid), 64'd0);
                end
                if (out_valid) begin
                    check("in_ready_low_while_valid", 64'(in_ready), 64'd0);
                    if (prev_valid && !prev_ready) begin
                        check("hold_data", 64'(out_data), 64'(prev_data));
                        check("hold_err", 64'(out_err), 64'(prev_err));
                    end
                    if (!seen) begin
                        seen = 1'b1;
                        if (sb.size() == 0)
                            fail_now("unexpected_out_valid");
                        else
                            check("latency", 64'(cyc - accept_cyc + 1), 64'(sb[0].lat));
                    end
                    if (out_ready) begin
                        if (sb.size() == 0) begin
                            fail_now("unexpected_output");
                        end else begin
                            e = sb.pop_front();
                            check("out_data", 64'(out_data), 64'(e.data));
                            check("out_err", 64'(out_err), 64'(e.err));
                        end
                        seen = 1'b0;
                    end
                end
                prev_hs    = out_valid && out_ready;
                prev_valid = out_valid;
                prev_ready = out_ready;
                prev_data  = out_data;
                prev_err   = out_err;
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) fail_now("timeout_in_ready");
    endtask

    task automatic drive(input logic [3:0] shift, input logic [4:0] fill);
        wait_ready();
        in_valid = 1'b1;
        in_data  = base_word;
        in_shift = shift;
        in_fill  = fill;
        @(posedge clk); #1;
        accept_cyc = cyc;
        // Scramble inputs after acceptance; the block must ignore them.
        in_valid = 1'b0;
        in_data  = '1;
        in_shift = 4'hF;
        in_fill  = 5'h00;
    endtask

    task automatic send(input logic [3:0] shift, input logic [4:0] fill,
                        input logic [W-1:0] exp_data, input logic exp_err,
                        input int exp_lat, input int hold);
        exp_t e;
        int   n;
        e.data = exp_data; e.err = exp_err; e.lat = exp_lat;
        sb.push_back(e);
        out_ready = (hold == 0);
        drive(shift, fill);
        if (hold > 0) begin
            n = 0;
            while (!out_valid && n < 50) begin
                @(posedge clk); #1;
                n++;
            end
            if (!out_valid) fail_now("timeout_out_valid");
            repeat (hold) @(posedge clk);
            #1;
            out_ready = 1'b1;
        end
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (sb.size() != 0) begin
            fail_now("timeout_result");
            sb.delete();
        end
    endtask

    initial begin
        for (int i = 0; i < 10; i++) base_word[i*5 +: 5] = 5'(i);
        in_valid = 1'b0; in_data = '0; in_shift = '0; in_fill = '0; out_ready = 1'b1;
        rst = 1'b0;
        #1 rst = 1'b1;
        #2;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_out_err", 64'(out_err), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Pass-through, multi-pass, full shift, error, extra patterns.
        send(4'd0,  5'h1F, mk_word(0, 1, 2, 3, 4, 5, 6, 7, 8, 9), 1'b0, 1, 0);
        send(4'd7,  5'h1F, mk_word(7, 8, 9, 31, 31, 31, 31, 31, 31, 31), 1'b0, 3, 0);
        send(4'd10, 5'h0A, mk_word(10, 10, 10, 10, 10, 10, 10, 10, 10, 10), 1'b0, 4, 0);
        send(4'd13, 5'h03, mk_word(3, 3, 3, 3, 3, 3, 3, 3, 3, 3), 1'b1, 4, 0);
        // Backpressure for 5 cycles; also clears the previous error flag.
        send(4'd4,  5'h03, mk_word(4, 5, 6, 7, 8, 9, 3, 3, 3, 3), 1'b0, 2, 5);
        send(4'd5,  5'h00, mk_word(5, 6, 7, 8, 9, 0, 0, 0, 0, 0), 1'b0, 3, 0);
        send(4'd8,  5'h1E, mk_word(8, 9, 30, 30, 30, 30, 30, 30, 30, 30), 1'b0, 3, 0);
        send(4'd15, 5'h11, mk_word(17, 17, 17, 17, 17, 17, 17, 17, 17, 17), 1'b1, 4, 0);

        // Reset in the second SHIFT cycle of a shift=9 request.
        out_ready = 1'b1;
        drive(4'd9, 5'h07);
        @(posedge clk); #2;
        check("busy_mid_shift", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_out_err", 64'(out_err), 64'd0);
        check("midrst_out_data", 64'(out_data), 64'd0);
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        send(4'd1, 5'h15, mk_word(1, 2, 3, 4, 5, 6, 7, 8, 9, 21), 1'b0, 2, 0);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "global timeout");
    end

endmodule
